regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 32, SHALL set the data width and register count.
REQ-002 Parameter ADDRES, default $clog2(WORD_SIZE), SHALL set the register address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous, active-low.
REQ-005 req0_valid  input  1  SHALL be the ALU writeback request.
REQ-006 req0_addres  input  ADDRES  SHALL be the ALU destination register.
REQ-007 req0_data  input  WORD_SIZE  SHALL be the ALU result.
REQ-008 req0_ready  output  1  SHALL be the ALU grant, combinational.
REQ-009 req1_valid, req1_addres, req1_data, req1_ready SHALL be the load-unit requester, with widths and meaning as for req0.
REQ-010 signal_we  output  1  SHALL be the register-file write enable.
REQ-011 addres_write  output  ADDRES  SHALL be the register-file write address.
REQ-012 data_write  output  WORD_SIZE  SHALL be the register-file write data.
REQ-013 conflict_cnt  output  16  SHALL count the cycles in which both requesters are valid.

Function
REQ-014 The arbiter SHALL share the single register-file write port between req0 and req1 using round-robin arbitration.
REQ-015 A transfer SHALL occur on a posedge where reqN_valid and reqN_ready are both 1.
REQ-016 At most one of req0_ready and req1_ready SHALL be 1 in any cycle.
REQ-017 reqN_ready SHALL be 0 whenever reqN_valid is 0.
REQ-018 One requester valid: that requester SHALL get ready=1 in the same cycle, regardless of the pointer.
REQ-019 Both requesters valid: the requester selected by the priority pointer SHALL get ready=1.
REQ-020 Pointer (state LAST0/LAST1) SHALL hold the most recently granted requester.
- Priority SHALL go to the other requester.
- Pointer SHALL update only on a transfer.
REQ-021 Latency: a transfer at edge N SHALL drive signal_we=1, addres_write=addr and data_write=data for exactly the cycle following edge N.
- The register file captures the write at edge N+1.
- Outputs SHALL be registered.
REQ-022 Back-to-back transfers SHALL be accepted every cycle, with no bubble; throughput is 1 write per cycle.
REQ-023 Without a transfer at edge N, signal_we SHALL be 0 in the next cycle.
- addres_write and data_write SHALL hold their last values.
REQ-024 A transfer with addres 0 (register $zero) SHALL be accepted.
- The pointer SHALL update.
- signal_we SHALL stay 0.
- addres_write and data_write SHALL be unchanged.
REQ-025 Both requesters valid with the same addres: only the granted write SHALL issue that cycle.
- The other SHALL issue in the next cycle if it is still valid (last-writer order = grant order).
REQ-026 conflict_cnt SHALL increment on every edge where req0_valid and req1_valid are both 1.
- It SHALL saturate at 16'hFFFF.
REQ-027 Requesters SHALL hold valid, addres and data stable until ready; the arbiter is not required to tolerate withdrawal.

Reset
REQ-028 rst_n=0 SHALL immediately force the following, independent of clk:
- signal_we=0, addres_write=0, data_write=0
- conflict_cnt=0
- pointer=LAST1 (req0 has priority first)
REQ-029 While rst_n=0, req0_ready and req1_ready SHALL be 0.
REQ-030 A transfer handshaked at the edge where reset asserts SHALL be discarded; no write SHALL issue after reset.
REQ-031 The first edge after rst_n rises SHALL arbitrate normally.

Verification
REQ-032 Reset, then req0 writes A1B1C1D1 to reg 1:
- req0_ready=1 in the same cycle.
- Next cycle: signal_we=1, addres_write=1, data_write=A1B1C1D1.
- Cycle after: signal_we=0.
REQ-033 Both valid for 4 cycles (req0 to reg 2 = A2B2C2D2, req1 to reg 3 = A3B3C3D3, each held until granted, then reissued):
- Grants SHALL alternate 0,1,0,1.
- conflict_cnt=4.
REQ-034 req1 alone writes reg 0 = FFFFFFFF:
- req1_ready=1.
- signal_we stays 0.
- Pointer=LAST1, so req0 wins the next conflict.
REQ-035 Both valid, same addres 6 (req0 = 11111111, req1 = 22222222):
- Two consecutive writes to reg 6 in grant order.
- Final register value SHALL equal the second grant's data.
REQ-036 Assert rst_n=0 mid-cycle while signal_we=1:
- signal_we SHALL drop immediately, before the next clk edge.
- conflict_cnt SHALL read 0.
- After release, a req0 write to reg 5 = A5B5C5D5 issues with 1-cycle latency.
REQ-037 Force conflict_cnt to FFFE, then hold both requesters valid for 3 cycles: conflict_cnt SHALL read FFFF.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Round-robin arbiter that shares the single register-file write port
//   between the ALU (req0) and the load unit (req1). A transfer happens on a
//   posedge where reqN_valid and reqN_ready are both 1. The granted write is
//   presented on the registered write-port outputs for exactly the following
//   cycle. Writes to register 0 are accepted but never issued.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_valid/addres/data     ALU writeback request
//   req0_ready                 ALU grant (combinational)
//   req1_valid/addres/data     load-unit writeback request
//   req1_ready                 load-unit grant (combinational)
//   signal_we                  register-file write enable (registered)
//   addres_write, data_write   register-file write address/data (registered)
//   conflict_cnt               saturating count of cycles with both requesters valid
//
// State (priority pointer)
//   state | meaning
//   LAST0 | req0 granted most recently, req1 wins the next conflict
//   LAST1 | req1 granted most recently (reset value), req0 wins the next conflict
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int ADDRES    = $clog2(WORD_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [ADDRES-1:0]    req0_addres,
    input  logic [WORD_SIZE-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [ADDRES-1:0]    req1_addres,
    input  logic [WORD_SIZE-1:0] req1_data,
    output logic                 req1_ready,
    output logic                 signal_we,
    output logic [ADDRES-1:0]    addres_write,
    output logic [WORD_SIZE-1:0] data_write,
    output logic [15:0]          conflict_cnt
);

    typedef enum logic {LAST0 = 1'b0, LAST1 = 1'b1} ptr_t;

    ptr_t                 state;
    ptr_t                 state_next;
    logic                 grant0;
    logic                 grant1;
    logic [ADDRES-1:0]    sel_addres;
    logic [WORD_SIZE-1:0] sel_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LAST1;
        end else begin
            state <= state_next;
        end
    end

    // Grants are gated by rst_n so nothing is handshaked while reset is held.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        if (rst_n) begin
            if (req0_valid && !req1_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid && !req0_valid) begin
                grant1 = 1'b1;
            end else if (req0_valid && req1_valid) begin
                if (state == LAST1) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end
        end
        if (grant0) begin
            state_next = LAST0;
        end else if (grant1) begin
            state_next = LAST1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign sel_addres = grant1 ? req1_addres : req0_addres;
    assign sel_data   = grant1 ? req1_data   : req0_data;

    // Register 0 is hardwired: the transfer completes but the port stays idle
    // and the last address/data are left untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signal_we    <= 1'b0;
            addres_write <= '0;
            data_write   <= '0;
        end else if ((grant0 || grant1) && (sel_addres != '0)) begin
            signal_we    <= 1'b1;
            addres_write <= sel_addres;
            data_write   <= sel_data;
        end else begin
            signal_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= 16'h0000;
        end else if (req0_valid && req1_valid && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'h0001;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter. Inputs change 1 time unit after the
//   rising edge; outputs are sampled on the falling edge. A small register
//   array captures the write port to check the final value of a register.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int WORD_SIZE = 32;
    localparam int ADDRES    = 5;

    logic                 clk;
    logic                 rst_n;
    logic                 req0_valid;
    logic [ADDRES-1:0]    req0_addres;
    logic [WORD_SIZE-1:0] req0_data;
    logic                 req0_ready;
    logic                 req1_valid;
    logic [ADDRES-1:0]    req1_addres;
    logic [WORD_SIZE-1:0] req1_data;
    logic                 req1_ready;
    logic                 signal_we;
    logic [ADDRES-1:0]    addres_write;
    logic [WORD_SIZE-1:0] data_write;
    logic [15:0]          conflict_cnt;

    logic [WORD_SIZE-1:0] rf [0:WORD_SIZE-1];

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_arbiter #(
        .WORD_SIZE(WORD_SIZE),
        .ADDRES   (ADDRES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_addres (req0_addres),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addres (req1_addres),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .signal_we   (signal_we),
        .addres_write(addres_write),
        .data_write  (data_write),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (signal_we) rf[addres_write] <= data_write;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < WORD_SIZE; i++) rf[i] = '0;
        rst_n       = 1'b0;
        req0_valid  = 1'b1;
        req0_addres = 5'd4;
        req0_data   = 32'h0BAD_0BAD;
        req1_valid  = 1'b1;
        req1_addres = 5'd4;
        req1_data   = 32'h0BAD_0BAD;

        // reset state, with both requesters valid
        #12;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_we", signal_we, 1'b0);
        chk("rst_addr", addres_write, 5'd0);
        chk("rst_data", data_write, 32'h0);
        chk("rst_cnt", conflict_cnt, 16'h0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        rst_n = 1'b1;

        // single req0 write, 1-cycle latency
        req0_valid  = 1'b1;
        req0_addres = 5'd1;
        req0_data   = 32'hA1B1C1D1;
        @(negedge clk);
        chk("w1_ready0", req0_ready, 1'b1);
        chk("w1_ready1", req1_ready, 1'b0);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("w1_we", signal_we, 1'b1);
        chk("w1_addr", addres_write, 5'd1);
        chk("w1_data", data_write, 32'hA1B1C1D1);
        step();
        @(negedge clk);
        chk("w1_we_off", signal_we, 1'b0);
        chk("w1_addr_hold", addres_write, 5'd1);
        chk("w1_data_hold", data_write, 32'hA1B1C1D1);

        // round robin, fresh pointer after reset
        step();
        reset_pulse();
        req0_valid  = 1'b1;
        req0_addres = 5'd2;
        req0_data   = 32'hA2B2C2D2;
        req1_valid  = 1'b1;
        req1_addres = 5'd3;
        req1_data   = 32'hA3B3C3D3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_ready0", req0_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("rr_ready1", req1_ready, (i % 2 == 1) ? 1'b1 : 1'b0);
            if (i > 0) begin
                chk("rr_we", signal_we, 1'b1);
                chk("rr_addr", addres_write, (i % 2 == 1) ? 5'd2 : 5'd3);
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("rr_last_addr", addres_write, 5'd3);
        chk("rr_last_data", data_write, 32'hA3B3C3D3);
        chk("rr_cnt", conflict_cnt, 16'd4);

        // req1 writes $zero: accepted, no write issued
        step();
        req1_valid  = 1'b1;
        req1_addres = 5'd0;
        req1_data   = 32'hFFFFFFFF;
        @(negedge clk);
        chk("z_ready1", req1_ready, 1'b1);
        chk("z_ready0", req0_ready, 1'b0);
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("z_we", signal_we, 1'b0);
        chk("z_addr_hold", addres_write, 5'd3);
        chk("z_data_hold", data_write, 32'hA3B3C3D3);

        // same-address conflict, pointer LAST1 so req0 first
        step();
        req0_valid  = 1'b1;
        req0_addres = 5'd6;
        req0_data   = 32'h11111111;
        req1_valid  = 1'b1;
        req1_addres = 5'd6;
        req1_data   = 32'h22222222;
        @(negedge clk);
        chk("sa_ready0", req0_ready, 1'b1);
        chk("sa_ready1", req1_ready, 1'b0);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("sa_ready1_2nd", req1_ready, 1'b1);
        chk("sa_we1", signal_we, 1'b1);
        chk("sa_data1", data_write, 32'h11111111);
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("sa_we2", signal_we, 1'b1);
        chk("sa_addr2", addres_write, 5'd6);
        chk("sa_data2", data_write, 32'h22222222);
        step();
        @(negedge clk);
        chk("sa_rf6", rf[6], 32'h22222222);
        chk("sa_we_off", signal_we, 1'b0);
        chk("sa_cnt", conflict_cnt, 16'd5);

        // asynchronous reset while a write is on the port
        step();
        req0_valid  = 1'b1;
        req0_addres = 5'd7;
        req0_data   = 32'h77777777;
        step();
        req0_valid = 1'b0;
        chk("ar_we_before", signal_we, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we", signal_we, 1'b0);
        chk("ar_addr", addres_write, 5'd0);
        chk("ar_data", data_write, 32'h0);
        chk("ar_cnt", conflict_cnt, 16'h0);
        step();
        rst_n       = 1'b1;
        req0_valid  = 1'b1;
        req0_addres = 5'd5;
        req0_data   = 32'hA5B5C5D5;
        @(negedge clk);
        chk("ar_ready0", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("ar_w_we", signal_we, 1'b1);
        chk("ar_w_addr", addres_write, 5'd5);
        chk("ar_w_data", data_write, 32'hA5B5C5D5);

        // conflict counter saturation
        step();
        reset_pulse();
        req0_valid  = 1'b1;
        req0_addres = 5'd8;
        req0_data   = 32'h88888888;
        req1_valid  = 1'b1;
        req1_addres = 5'd9;
        req1_data   = 32'h99999999;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat_fffe", conflict_cnt, 16'hFFFE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat_ffff", conflict_cnt, 16'hFFFF);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
